// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Byte-serial instruction fetch unit. Reads one program-memory byte
//            per cycle, assembles 1-byte and 2-byte instructions and presents
//            them to decode through a valid/ready handshake. A branch redirect
//            flushes any partial or presented instruction and restarts fetch.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1  rising-edge clock
//   reset           in   1  asynchronous active-low reset
//   address_bus     out  8  program-memory byte address (the PC register)
//   data_bus        in   8  program-memory byte at address_bus, same cycle
//   instr_valid     out  1  instruction presented to decode
//   instr_ready     in   1  decode accepts the presented instruction
//   instr_op        out  8  first instruction byte
//   instr_imm       out  8  second byte of 2-byte instructions, else 0
//   instr_len       out  1  0 = 1-byte, 1 = 2-byte instruction
//   instr_pc        out  8  address of instr_op
//   redirect_valid  in   1  branch taken: flush and refetch
//   redirect_target in   8  new PC while redirect_valid is high
// ============================================================================
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] address_bus,
    input  logic [7:0] data_bus,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_op,
    output logic [7:0] instr_imm,
    output logic       instr_len,
    output logic [7:0] instr_pc,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_target
);

    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    // Opcode classes that carry an immediate byte.
    function automatic logic is_two_byte(input logic [7:0] b);
        logic two;
        two = 1'b0;
        if (b[7:2] == 6'b100000) two = 1'b1;   // MOV_IMM
        if (b[7:2] == 6'b100011) two = 1'b1;   // CMP_IMM
        if (b[7:3] == 5'b10101)  two = 1'b1;   // BRA
        if (b[7:3] == 5'b10110)  two = 1'b1;   // BHI / BEQ
        return two;
    endfunction

    state_t     state_q,   state_d;
    logic [7:0] pc_q,      pc_d;
    logic       valid_q,   valid_d;
    logic [7:0] op_q,      op_d;
    logic [7:0] imm_q,     imm_d;
    logic       len_q,     len_d;
    logic [7:0] ipc_q,     ipc_d;
    logic [7:0] sav_op_q,  sav_op_d;
    logic [7:0] sav_pc_q,  sav_pc_d;

    logic       adv;
    logic       two_byte;
    logic [7:0] pc_inc;

    // The output slot may be overwritten when it is empty or being consumed.
    assign adv      = !valid_q || instr_ready;
    assign two_byte = is_two_byte(data_bus);
    // 8-bit add wraps naturally, including between op and imm bytes.
    assign pc_inc   = pc_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        op_d     = op_q;
        imm_d    = imm_q;
        len_d    = len_q;
        ipc_d    = ipc_q;
        sav_op_d = sav_op_q;
        sav_pc_d = sav_pc_q;

        if (redirect_valid) begin
            // Redirect beats everything: the presented instruction is dropped
            // even if decode is accepting it, and any half-fetched op is lost.
            pc_d     = redirect_target;
            state_d  = FETCH_OP;
            valid_d  = 1'b0;
            sav_op_d = 8'h00;
            sav_pc_d = 8'h00;
        end else if (adv) begin
            case (state_q)
                FETCH_OP: begin
                    if (two_byte) begin
                        sav_op_d = data_bus;
                        sav_pc_d = pc_q;
                        pc_d     = pc_inc;
                        // adv implies the slot is empty or being consumed now,
                        // so nothing remains presented while the imm is read.
                        valid_d  = 1'b0;
                        state_d  = FETCH_IMM;
                    end else begin
                        op_d    = data_bus;
                        imm_d   = 8'h00;
                        len_d   = 1'b0;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end
                FETCH_IMM: begin
                    op_d    = sav_op_q;
                    imm_d   = data_bus;
                    len_d   = 1'b1;
                    ipc_d   = sav_pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    state_d = FETCH_OP;
                end
                default: begin
                    state_d = FETCH_OP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH_OP;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            op_q     <= 8'h00;
            imm_q    <= 8'h00;
            len_q    <= 1'b0;
            ipc_q    <= 8'h00;
            sav_op_q <= 8'h00;
            sav_pc_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            len_q    <= len_d;
            ipc_q    <= ipc_d;
            sav_op_q <= sav_op_d;
            sav_pc_q <= sav_pc_d;
        end
    end

    // All outputs come straight from registers; no input reaches them
    // combinationally.
    assign address_bus = pc_q;
    assign instr_valid = valid_q;
    assign instr_op    = op_q;
    assign instr_imm   = imm_q;
    assign instr_len   = len_q;
    assign instr_pc    = ipc_q;

endmodule
`default_nettype wire
